// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: instruction field positions, immediate marker bit,
// fetch FSM states and IF/ID bundle widths.
package fetch_stage_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned ADDR_W  = 16;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 10;
  localparam int unsigned SRC_MSB = 9;
  localparam int unsigned SRC_LSB = 7;
  localparam int unsigned DST_MSB = 6;
  localparam int unsigned DST_LSB = 4;

  localparam int unsigned IMM_BIT = 5;

  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int unsigned REG_W   = SRC_MSB - SRC_LSB + 1;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_IMM   = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset clears everything, flush drops only valid,
// enable gates updates and load selects whether the payload fields change.
module fetch_stage_if_id_reg #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               en,
  input  logic                               load,
  input  logic                               d_valid,
  input  logic [fetch_stage_pkg::OPC_W-1:0]  d_opcode,
  input  logic [fetch_stage_pkg::REG_W-1:0]  d_src,
  input  logic [fetch_stage_pkg::REG_W-1:0]  d_dst,
  input  logic [W-1:0]                       d_imm,
  input  logic                               d_has_imm,
  input  logic [AW-1:0]                      d_pc_next,
  output logic                               valid,
  output logic [fetch_stage_pkg::OPC_W-1:0]  opcode,
  output logic [fetch_stage_pkg::REG_W-1:0]  src,
  output logic [fetch_stage_pkg::REG_W-1:0]  dst,
  output logic [W-1:0]                       imm,
  output logic                               has_imm,
  output logic [AW-1:0]                      pc_next
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      opcode  <= '0;
      src     <= '0;
      dst     <= '0;
      imm     <= '0;
      has_imm <= 1'b0;
      pc_next <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= d_valid;
      if (load) begin
        opcode  <= d_opcode;
        src     <= d_src;
        dst     <= d_dst;
        imm     <= d_imm;
        has_imm <= d_has_imm;
        pc_next <= d_pc_next;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// First pipeline stage: owns the PC, reads instruction memory and assembles
// one- or two-word instructions into the IF/ID bundle.
module fetch_stage #(
  parameter int unsigned W        = 16,
  parameter int unsigned AW       = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned IMM_BIT  = fetch_stage_pkg::IMM_BIT
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [AW-1:0]                      imem_addr,
  input  logic [W-1:0]                       imem_data,
  input  logic                               stall,
  input  logic                               redirect,
  input  logic [AW-1:0]                      redirect_pc,
  output logic                               if_id_valid,
  output logic [fetch_stage_pkg::OPC_W-1:0]  if_id_opcode,
  output logic [fetch_stage_pkg::REG_W-1:0]  if_id_src,
  output logic [fetch_stage_pkg::REG_W-1:0]  if_id_dst,
  output logic [W-1:0]                       if_id_imm,
  output logic                               if_id_has_imm,
  output logic [AW-1:0]                      if_id_pc_next
);
  import fetch_stage_pkg::*;

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  fetch_state_e  state;
  logic [W-1:0]  hold_word;

  logic          two_word;
  logic [W-1:0]  insn;
  logic [W-1:0]  d_imm;
  logic          d_has_imm;
  logic          d_valid;
  logic          load;

  assign imem_addr = pc;
  assign pc_inc    = pc + AW'(1);
  assign two_word  = imem_data[OPC_LSB + IMM_BIT];

  // Select what the IF/ID register captures this cycle.
  always_comb begin
    insn      = imem_data;
    d_imm     = '0;
    d_has_imm = 1'b0;
    d_valid   = 1'b1;
    load      = 1'b1;
    if (state == S_IMM) begin
      insn      = hold_word;
      d_imm     = imem_data;
      d_has_imm = 1'b1;
    end else if (two_word) begin
      d_valid = 1'b0;
      load    = 1'b0;
    end
  end

  // PC and fetch FSM; a redirect discards any half-fetched two-word instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= AW'(RESET_PC);
      state     <= S_FIRST;
      hold_word <= '0;
    end else if (redirect) begin
      pc    <= redirect_pc;
      state <= S_FIRST;
    end else if (!stall) begin
      pc <= pc_inc;
      case (state)
        S_FIRST: begin
          if (two_word) begin
            hold_word <= imem_data;
            state     <= S_IMM;
          end
        end
        S_IMM:   state <= S_FIRST;
        default: state <= S_FIRST;
      endcase
    end
  end

  fetch_stage_if_id_reg #(
    .W  (W),
    .AW (AW)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .en        (!stall),
    .load      (load),
    .d_valid   (d_valid),
    .d_opcode  (insn[OPC_MSB:OPC_LSB]),
    .d_src     (insn[SRC_MSB:SRC_LSB]),
    .d_dst     (insn[DST_MSB:DST_LSB]),
    .d_imm     (d_imm),
    .d_has_imm (d_has_imm),
    .d_pc_next (pc_inc),
    .valid     (if_id_valid),
    .opcode    (if_id_opcode),
    .src       (if_id_src),
    .dst       (if_id_dst),
    .imm       (if_id_imm),
    .has_imm   (if_id_has_imm),
    .pc_next   (if_id_pc_next)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed program with a scoreboard of expected IF/ID bundles
// plus cycle-level checks of imem_addr, bubbles, stall hold and reset.
module tb_fetch_stage;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [15:0] imm;
    logic        has_imm;
    logic [15:0] pc_next;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_id_valid;
  logic [5:0]  if_id_opcode;
  logic [2:0]  if_id_src;
  logic [2:0]  if_id_dst;
  logic [15:0] if_id_imm;
  logic        if_id_has_imm;
  logic [15:0] if_id_pc_next;

  logic [15:0] mem [0:65535];
  exp_t        sb [$];
  logic        fresh = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .if_id_valid   (if_id_valid),
    .if_id_opcode  (if_id_opcode),
    .if_id_src     (if_id_src),
    .if_id_dst     (if_id_dst),
    .if_id_imm     (if_id_imm),
    .if_id_has_imm (if_id_has_imm),
    .if_id_pc_next (if_id_pc_next)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A valid bundle is a new instruction only if the edge that produced it was a normal advance.
  always @(posedge clk) fresh <= !rst && !redirect && !stall;

  // Monitor: pop and compare every newly presented instruction.
  always @(negedge clk) begin
    if (if_id_valid === 1'b1 && fresh) begin
      exp_t e;
      exp_t a;
      n_tests++;
      a = {if_id_opcode, if_id_src, if_id_dst, if_id_imm, if_id_has_imm, if_id_pc_next};
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_insn: got op=%h src=%0d dst=%0d imm=%h has=%0d pcn=%h, required none",
                 a.opcode, a.src, a.dst, a.imm, a.has_imm, a.pc_next);
      end else begin
        e = sb.pop_front();
        if (a !== e)
          begin
            n_fail++;
            $display("FAIL bundle: got op=%h src=%0d dst=%0d imm=%h has=%0d pcn=%h, required op=%h src=%0d dst=%0d imm=%h has=%0d pcn=%h",
                     a.opcode, a.src, a.dst, a.imm, a.has_imm, a.pc_next,
                     e.opcode, e.src, e.dst, e.imm, e.has_imm, e.pc_next);
          end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [2:0] s, input logic [2:0] d,
                      input logic [15:0] imm, input logic has, input logic [15:0] pcn);
    exp_t e;
    e = '{opcode: op, src: s, dst: d, imm: imm, has_imm: has, pc_next: pcn};
    sb.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0A10;
    mem[16'h0001] = 16'h8230;
    mem[16'h0002] = 16'hBEEF;
    mem[16'h0003] = 16'h1C50;
    mem[16'h0004] = 16'h8400;
    mem[16'h0005] = 16'h1234;
    mem[16'h0006] = 16'h8000;
    mem[16'h0040] = 16'h2590;
    mem[16'hFFFF] = 16'h3C20;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_valid", 32'(if_id_valid), 32'h0);
    end

    // Sequential one-word / two-word / one-word stream.
    rst = 1'b0;
    push(6'h02, 3'd4, 3'd1, 16'h0000, 1'b0, 16'h0001);
    push(6'h20, 3'd4, 3'd3, 16'hBEEF, 1'b1, 16'h0003);
    push(6'h07, 3'd0, 3'd5, 16'h0000, 1'b0, 16'h0004);
    tick(); chk("addr_after_first", 32'(imem_addr), 32'h1);
    tick(); chk("two_word_bubble", 32'(if_id_valid), 32'h0);
            chk("addr_imm_word", 32'(imem_addr), 32'h2);
    tick(); chk("addr_after_imm", 32'(imem_addr), 32'h3);
    tick();

    // Stall three cycles with a one-word instruction in IF/ID.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(if_id_valid), 32'h1);
      chk("stall_opcode", 32'(if_id_opcode), 32'h07);
      chk("stall_dst", 32'(if_id_dst), 32'h5);
      chk("stall_pc_next", 32'(if_id_pc_next), 32'h4);
      chk("stall_addr", 32'(imem_addr), 32'h4);
    end

    // Resume; stall once inside S_IMM, immediate re-sampled afterwards.
    stall = 1'b0;
    push(6'h21, 3'd0, 3'd0, 16'h1234, 1'b1, 16'h0006);
    tick(); chk("resume_bubble", 32'(if_id_valid), 32'h0);
            chk("resume_addr", 32'(imem_addr), 32'h5);
    stall = 1'b1;
    tick(); chk("imm_stall_valid", 32'(if_id_valid), 32'h0);
            chk("imm_stall_addr", 32'(imem_addr), 32'h5);
    stall = 1'b0;
    tick(); chk("after_imm_addr", 32'(imem_addr), 32'h6);

    // Redirect with simultaneous stall while in S_IMM.
    tick(); chk("pre_redir_bubble", 32'(if_id_valid), 32'h0);
            chk("pre_redir_addr", 32'(imem_addr), 32'h7);
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    tick(); chk("redir_valid", 32'(if_id_valid), 32'h0);
            chk("redir_addr", 32'(imem_addr), 32'h40);
    redirect = 1'b0; stall = 1'b0;
    push(6'h09, 3'd3, 3'd1, 16'h0000, 1'b0, 16'h0041);
    tick(); chk("post_redir_addr", 32'(imem_addr), 32'h41);

    // PC wrap at 0xFFFF.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick(); chk("wrap_redir_valid", 32'(if_id_valid), 32'h0);
            chk("wrap_redir_addr", 32'(imem_addr), 32'hFFFF);
    redirect = 1'b0;
    push(6'h0F, 3'd0, 3'd2, 16'h0000, 1'b0, 16'h0000);
    tick(); chk("wrap_addr", 32'(imem_addr), 32'h0);

    // Reset in the middle of a two-word fetch, with stall asserted.
    redirect = 1'b1; redirect_pc = 16'h0001;
    tick(); chk("redir1_addr", 32'(imem_addr), 32'h1);
    redirect = 1'b0;
    tick(); chk("mid_imm_addr", 32'(imem_addr), 32'h2);
            chk("mid_imm_bubble", 32'(if_id_valid), 32'h0);
    rst = 1'b1; stall = 1'b1;
    tick();
    chk("rst2_addr", 32'(imem_addr), 32'h0);
    chk("rst2_valid", 32'(if_id_valid), 32'h0);
    chk("rst2_opcode", 32'(if_id_opcode), 32'h0);
    chk("rst2_src", 32'(if_id_src), 32'h0);
    chk("rst2_dst", 32'(if_id_dst), 32'h0);
    chk("rst2_imm", 32'(if_id_imm), 32'h0);
    chk("rst2_has_imm", 32'(if_id_has_imm), 32'h0);
    chk("rst2_pc_next", 32'(if_id_pc_next), 32'h0);
    rst = 1'b0; stall = 1'b0;
    push(6'h02, 3'd4, 3'd1, 16'h0000, 1'b0, 16'h0001);
    tick(); chk("rst2_resume_addr", 32'(imem_addr), 32'h1);
    stall = 1'b1;
    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- First pipeline stage. Owns the PC, drives the instruction-memory read port, and assembles one- or two-word instructions.
- Presents a registered IF/ID bundle (opcode, src, dst, immediate, valid) to the decode stage.
- Honours stall from hazard detection and redirect from EX (branch/jump).
- Two-word instructions carry a 16-bit immediate in the second word, so fetch runs a small FSM.

Parameters:
- W, 16, instruction word and immediate width.
- AW, 16, PC / instruction-memory address width.
- RESET_PC, 0, PC value after reset.
- IMM_BIT, 5, opcode bit that marks a two-word (immediate) instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  AW  instruction-memory address; combinational from the PC.
- imem_data  in  W  instruction word at imem_addr; valid in the same cycle.
- stall  in  1  hold PC, FSM and IF/ID register.
- redirect  in  1  branch/jump taken; flush and load the target.
- redirect_pc  in  AW  new PC when redirect=1.
- if_id_valid  out  1  bundle holds a complete instruction.
- if_id_opcode  out  6  imem word bits [15:10].
- if_id_src  out  3  bits [9:7].
- if_id_dst  out  3  bits [6:4].
- if_id_imm  out  W  second word; 0 for one-word instructions.
- if_id_has_imm  out  1  instruction was two-word.
- if_id_pc_next  out  AW  address following the complete instruction (return address for CALL).

Behaviour:
- Word fields: opcode=[15:10], src=[9:7], dst=[6:4]; bits [3:0] are ignored.
- Registers: pc, state {S_FIRST, S_IMM}, hold_word (W), and the IF/ID outputs.
- imem_addr = pc at all times.
- Reset (rst=1 at a clock edge):
  - pc<=RESET_PC, state<=S_FIRST, hold_word<=0.
  - All if_id_* <= 0, including if_id_valid.
  - Reset wins over every other input, including mid-way through a two-word fetch.
- Priority each edge: rst > redirect > stall > normal.
- redirect=1:
  - pc<=redirect_pc, state<=S_FIRST, if_id_valid<=0.
  - Other if_id_* fields hold their values (don't-care).
  - Any half-fetched two-word instruction is discarded.
  - Redirect overrides a simultaneous stall.
- stall=1 (no redirect): pc, state, hold_word and all if_id_* hold.
- Normal, state S_FIRST, w=imem_data:
  - If w[10+IMM_BIT]=0 (one-word):
    - if_id_valid<=1, fields from w, if_id_imm<=0, if_id_has_imm<=0.
    - if_id_pc_next<=pc+1, pc<=pc+1.
  - Else (two-word):
    - hold_word<=w, pc<=pc+1, state<=S_IMM, if_id_valid<=0 (bubble).
- Normal, state S_IMM:
  - if_id_valid<=1, fields from hold_word, if_id_imm<=imem_data, if_id_has_imm<=1.
  - if_id_pc_next<=pc+1, pc<=pc+1, state<=S_FIRST.
- Latency: one-word instruction appears 1 cycle after its address is presented; two-word after 2 cycles with one bubble.
- Throughput: one instruction/cycle (one-word), one per 2 cycles (two-word).
- PC arithmetic is modulo 2^AW; 0xFFFF+1 wraps to 0x0000 silently.
- A stall during S_IMM keeps hold_word and re-samples imem_data at the same pc once released.

Decomposition:
- Shared package:
  - instruction field positions (OPC_MSB/LSB, SRC_MSB/LSB, DST_MSB/LSB);
  - IMM_BIT;
  - the fetch state enum;
  - the IF/ID bundle widths (so the decode and ID/EX stages use the same constants).
- One natural sub-module: if_id_reg, holding the IF/ID register with enable (~stall) and synchronous clear (rst | redirect).
- PC register and FSM stay in fetch_stage.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, then release with imem[0]=0x0A10 (opcode 0x02, src 4, dst 1, one-word).
  - Required: during reset imem_addr=0 and if_id_valid=0; next edge gives valid=1, opcode=0x02, src=4, dst=1, imm=0, pc_next=1.
- Two-word:
  - Stimulus: imem[1]=0x8230 (opcode 0x20, IMM_BIT set), imem[2]=0xBEEF.
  - Required: after the imem[1] edge, valid=0; after the imem[2] edge, valid=1, opcode=0x20, src=4, dst=3, imm=0xBEEF, has_imm=1, pc_next=3.
- Stall:
  - Stimulus: assert stall for 3 cycles while a one-word instruction sits in IF/ID.
  - Required: all outputs and imem_addr are constant for those 3 cycles; fetch resumes at the same pc afterwards.
- Redirect mid-immediate:
  - Stimulus: in S_IMM, assert redirect=1 with redirect_pc=0x0040 and stall=1.
  - Required: next edge gives pc=0x0040 and valid=0; the instruction at 0x0040 is decoded fresh from S_FIRST.
- Wrap:
  - Stimulus: redirect to 0xFFFF with a one-word instruction there.
  - Required: pc_next=0x0000, and the next imem_addr is 0x0000.
- Reset mid-operation:
  - Stimulus: rst=1 while in S_IMM with stall=1.
  - Required: state=S_FIRST, pc=RESET_PC, all outputs 0 after that edge.
